// File: rtl/shift_tx_ctrl.sv
// Transmit sequencer for a parallel-load/left-shift register: accepts a word over
// valid/ready, pulses LD then N SH, streams the register MSB on SOUT.
// Optional trailing even-parity bit when SHIFT_TX_CTRL_PARITY_EN is defined.
module shift_tx_ctrl #(
  parameter int   N    = 8,
  parameter int   DIV  = 4,
  parameter logic FILL = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] DIN,
  input  logic         VALID,
  output logic         READY,
  output logic [N-1:0] D_OUT,
  output logic         LD,
  output logic         SH,
  output logic         SER_IN,
  input  logic         Q_MSB,
  output logic         SOUT,
  output logic         BUSY,
  output logic         DONE
);
  localparam int BW = $clog2(N + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
`ifdef SHIFT_TX_CTRL_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q;
  logic [N-1:0]   word_q;
  logic [BW-1:0]  bit_q;
  logic [DW-1:0]  div_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (VALID) begin
          word_q  <= DIN;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          bit_q   <= '0;
          div_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // SH fires on the last clock of each period, so the register advances
          // exactly as the period rolls over
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_DONE;
`endif
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
`ifdef SHIFT_TX_CTRL_PARITY_EN
        S_PARITY: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            state_q <= S_DONE;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign READY  = (state_q == S_IDLE);
  assign BUSY   = (state_q != S_IDLE);
  assign LD     = (state_q == S_LOAD);
  assign SH     = (state_q == S_SHIFT) && (div_q == DIV_LAST);
  assign DONE   = (state_q == S_DONE);
  assign D_OUT  = word_q;
  assign SER_IN = FILL;

  always_comb begin
    SOUT = 1'b1;
    if (state_q == S_SHIFT) SOUT = Q_MSB;
`ifdef SHIFT_TX_CTRL_PARITY_EN
    if (state_q == S_PARITY) SOUT = ^word_q;
`endif
  end

endmodule
